// File: rtl/button_conditioner.sv
// button_conditioner: polarity normalisation, two-flop synchroniser and
// per-button debounce producing level, press/release pulses and a toggle.
module button_conditioner #(
   parameter int unsigned WIDTH      = 4,
   parameter int unsigned DEBOUNCE   = 500000,
   parameter int unsigned CNT_W      = 20,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] btn_raw,
   output logic [WIDTH-1:0] btn_level,
   output logic [WIDTH-1:0] btn_press,
   output logic [WIDTH-1:0] btn_release,
   output logic [WIDTH-1:0] btn_toggle
);

   // Count value on which a pending change is accepted
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_CHANGING = 1'b1
   } state_t;

   logic [WIDTH-1:0] w_norm;
   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;
   logic [WIDTH-1:0] r_level;
   logic [WIDTH-1:0] w_level_nxt;
   logic [CNT_W-1:0] r_cnt     [WIDTH];
   logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
   state_t           w_state   [WIDTH];
   logic [WIDTH-1:0] r_press;
   logic [WIDTH-1:0] r_release;
   logic [WIDTH-1:0] r_toggle;
   logic [WIDTH-1:0] w_press_nxt;
   logic [WIDTH-1:0] w_release_nxt;
   logic [WIDTH-1:0] w_toggle_nxt;

   // Map raw pins to 1 = pressed before they enter the clock domain
   assign w_norm = ACTIVE_LOW ? ~btn_raw : btn_raw;

   // Two-flop synchroniser into clk
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= w_norm;
         r_s2 <= r_s1;
      end
   end

   // Debounce state register: accepted level and per-button counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_level <= '0;
         for (int i = 0; i < int'(WIDTH); i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_level <= w_level_nxt;
         for (int i = 0; i < int'(WIDTH); i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
         end
      end
   end

   // Next-state logic: a mismatch must persist for DEBOUNCE cycles to be accepted
   always_comb begin
      w_level_nxt = r_level;
      for (int i = 0; i < int'(WIDTH); i++) begin
         w_cnt_nxt[i] = '0;
         w_state[i]   = (r_s2[i] != r_level[i]) ? ST_CHANGING : ST_STABLE;
         case (w_state[i])
            ST_STABLE: begin
               w_cnt_nxt[i] = '0;
            end
            ST_CHANGING: begin
               if (r_cnt[i] == CNT_LAST) begin
                  w_level_nxt[i] = r_s2[i];
                  w_cnt_nxt[i]   = '0;
               end else begin
                  w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
               end
            end
            default: begin
               w_cnt_nxt[i] = '0;
            end
         endcase
      end
   end

   // Output decode: pulses and toggle follow the accepted level change
   always_comb begin
      w_press_nxt   = w_level_nxt & ~r_level;
      w_release_nxt = ~w_level_nxt & r_level;
      w_toggle_nxt  = r_toggle ^ w_press_nxt;
   end

   // Registered pulse and toggle outputs, aligned with the level update
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_press   <= '0;
         r_release <= '0;
         r_toggle  <= '0;
      end else begin
         r_press   <= w_press_nxt;
         r_release <= w_release_nxt;
         r_toggle  <= w_toggle_nxt;
      end
   end

   assign btn_level   = r_level;
   assign btn_press   = r_press;
   assign btn_release = r_release;
   assign btn_toggle  = r_toggle;

endmodule
